// File: rtl/acc_cpu_pkg.sv
// acc_cpu shared types: opcode and state encodings
// plus the memory-operand predicate used by the decoder.
package acc_cpu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 4'd0,
        OP_STORE = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_BR    = 4'd7,
        OP_BZ    = 4'd8,
        OP_BC    = 4'd9,
        OP_LDI   = 4'd10,
        OP_SHL   = 4'd11,
        OP_SHR   = 4'd12,
        OP_NOP0  = 4'd13,
        OP_NOP1  = 4'd14,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALTED
    } state_e;

    function automatic logic is_mem_op(opcode_e op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/acc_alu.sv
// acc_cpu ALU: combinational result and carry for
// every accumulator-writing opcode.
module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int WORD_W = 12
) (
    input  logic [WORD_W-1:0] i_acc,
    input  logic [WORD_W-1:0] i_opnd,
    input  opcode_e           i_op,
    output logic [WORD_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_carry_vld
);

    logic [WORD_W:0] w_sum;

    always_comb begin
        o_result    = i_acc;
        o_carry     = 1'b0;
        o_carry_vld = 1'b0;
        w_sum       = '0;
        unique case (i_op)
            OP_LOAD, OP_LDI: o_result = i_opnd;
            OP_ADD: begin
                w_sum       = {1'b0, i_acc} + {1'b0, i_opnd};
                o_result    = w_sum[WORD_W-1:0];
                o_carry     = w_sum[WORD_W];
                o_carry_vld = 1'b1;
            end
            OP_SUB: begin
                // carry is the inverted borrow: 1 when ACC >= M
                w_sum       = {1'b0, i_acc} - {1'b0, i_opnd};
                o_result    = w_sum[WORD_W-1:0];
                o_carry     = ~w_sum[WORD_W];
                o_carry_vld = 1'b1;
            end
            OP_AND: o_result = i_acc & i_opnd;
            OP_OR:  o_result = i_acc | i_opnd;
            OP_XOR: o_result = i_acc ^ i_opnd;
            OP_SHL: begin
                o_result    = {i_acc[WORD_W-2:0], 1'b0};
                o_carry     = i_acc[WORD_W-1];
                o_carry_vld = 1'b1;
            end
            OP_SHR: begin
                o_result    = {1'b0, i_acc[WORD_W-1:1]};
                o_carry     = i_acc[0];
                o_carry_vld = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_cpu.sv
// Accumulator processor core: multi-cycle FSM with a single
// request/ready memory port that tolerates wait states.
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int WORD_W = 12,
    parameter int OP_W   = 4,
    parameter int ADDR_W = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic [WORD_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out
);

    state_e            r_state;
    state_e            w_state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nx;
    logic [WORD_W-1:0] r_ir;
    logic [WORD_W-1:0] r_acc;
    logic              r_z;
    logic              r_c;
    logic              w_ir_we;
    logic              w_acc_we;
    logic [OP_W-1:0]   w_op_field;
    logic [ADDR_W-1:0] w_opnd;
    opcode_e           w_op;
    logic [WORD_W-1:0] w_alu_m;
    logic [WORD_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_cv;
    logic              w_taken;

    assign w_op_field = r_ir[WORD_W-1 -: OP_W];
    assign w_opnd     = r_ir[ADDR_W-1:0];
    // codes above 15 on wider opcode fields decode as NOP
    assign w_op = ((w_op_field >> 4) == '0) ?
                  opcode_e'(w_op_field[3:0]) : OP_NOP0;

    assign w_alu_m = (r_state == S_EXECUTE) ?
                     mem_rdata : WORD_W'(w_opnd);

    acc_alu #(
        .WORD_W (WORD_W)
    ) u_alu (
        .i_acc       (r_acc),
        .i_opnd      (w_alu_m),
        .i_op        (w_op),
        .o_result    (w_alu_res),
        .o_carry     (w_alu_c),
        .o_carry_vld (w_alu_cv)
    );

    assign w_taken = (w_op == OP_BR) ||
                     ((w_op == OP_BZ) && r_z) ||
                     ((w_op == OP_BC) && r_c);

    assign mem_req   = !reset &&
                       ((r_state == S_FETCH) ||
                        (r_state == S_EXECUTE));
    assign mem_we    = !reset &&
                       (r_state == S_EXECUTE) &&
                       (w_op == OP_STORE);
    assign mem_addr  = (r_state == S_EXECUTE) ? w_opnd : r_pc;
    assign mem_wdata = r_acc;
    assign halted    = !reset && (r_state == S_HALTED);
    assign acc_out   = r_acc;
    assign pc_out    = r_pc;

    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_ir_we    = 1'b0;
        w_acc_we   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_ir_we    = 1'b1;
                    w_pc_nx    = r_pc + 1'b1;
                    w_state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nx = S_FETCH;
                unique case (1'b1)
                    is_mem_op(w_op):   w_state_nx = S_EXECUTE;
                    (w_op == OP_HALT): w_state_nx = S_HALTED;
                    default: begin
                        w_acc_we = (w_op inside {OP_LDI, OP_SHL, OP_SHR});
                        if (w_taken) begin
                            w_pc_nx = w_opnd;
                        end
                    end
                endcase
            end
            S_EXECUTE: begin
                if (mem_ready) begin
                    w_acc_we   = (w_op != OP_STORE);
                    w_state_nx = S_FETCH;
                end
            end
            S_HALTED: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_acc <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
        end else begin
            r_pc <= w_pc_nx;
            if (w_ir_we) begin
                r_ir <= mem_rdata;
            end
            if (w_acc_we) begin
                r_acc <= w_alu_res;
                r_z   <= (w_alu_res == '0);
                if (w_alu_cv) begin
                    r_c <= w_alu_c;
                end
            end
        end
    end

endmodule
